// File: rtl/branch_resolve.sv
// Branch resolution unit: computes targets at issue, carries them down a DEPTH-stage
// pipeline, resolves against ALU flags, trains a 2-bit BHT and flushes on redirect.
module branch_resolve #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 2,
  parameter int BHT_ENTRIES = 16,
  parameter int PC_OFFSET   = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [2:0]      issue_type,
  input  logic [XLEN-1:0] issue_pc,
  input  logic [XLEN-1:0] issue_imm,
  input  logic [XLEN-1:0] issue_rs1,
  input  logic            stall,
  input  logic            flag_eq,
  input  logic            flag_lt,
  output logic            predict_taken,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [15:0]     mispredict_count
);

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam int R  = DEPTH - 1;
  localparam logic [2:0] T_BEQ  = 3'b000;
  localparam logic [2:0] T_BNE  = 3'b001;
  localparam logic [2:0] T_JAL  = 3'b010;
  localparam logic [2:0] T_JALR = 3'b011;
  localparam logic [2:0] T_BLT  = 3'b100;
  localparam logic [2:0] T_BGE  = 3'b101;
  localparam logic [2:0] T_BLTU = 3'b110;
  localparam logic [2:0] T_BGEU = 3'b111;

  logic [XLEN-1:0] ia;
  logic [XLEN-1:0] issue_target;
  logic [XLEN-1:0] issue_fall;
  logic [IW-1:0]   issue_idx;
  logic            issue_cond;

  logic [1:0]      bht [BHT_ENTRIES];

  logic            p_valid  [DEPTH];
  logic [2:0]      p_type   [DEPTH];
  logic [XLEN-1:0] p_target [DEPTH];
  logic [XLEN-1:0] p_fall   [DEPTH];
  logic            p_pred   [DEPTH];
  logic [IW-1:0]   p_idx    [DEPTH];

  logic            r_cond;
  logic            r_taken;
  logic            r_mispredict;

  assign ia          = issue_pc - XLEN'(PC_OFFSET);
  assign issue_fall  = ia + XLEN'(4);
  assign issue_idx   = ia[IW+1:2];
  assign issue_cond  = (issue_type != T_JAL) && (issue_type != T_JALR);
  assign issue_target = (issue_type == T_JALR)
                      ? ((issue_rs1 + issue_imm) & {{(XLEN-1){1'b1}}, 1'b0})
                      : (ia + issue_imm);

  // Lookup reads the array before this edge's update, so same-index hits see the old count.
  assign predict_taken = !reset && issue_valid && issue_cond && bht[issue_idx][1];

  always_comb begin
    r_cond  = 1'b1;
    r_taken = 1'b0;
    case (p_type[R])
      T_BEQ:   r_taken = flag_eq;
      T_BNE:   r_taken = !flag_eq;
      T_BLT:   r_taken = flag_lt;
      T_BGE:   r_taken = !flag_lt;
      T_BLTU:  r_taken = flag_lt;
      T_BGEU:  r_taken = !flag_lt;
      default: begin
        r_cond  = 1'b0;
        r_taken = 1'b1;
      end
    endcase
  end

  assign r_mispredict = !stall && !reset && p_valid[R] && r_cond && (r_taken != p_pred[R]);

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (!stall && !reset && p_valid[R] && (!r_cond || (r_taken != p_pred[R]))) begin
      redirect    = 1'b1;
      redirect_pc = r_taken ? p_target[R] : p_fall[R];
    end
  end

  // A redirect squashes every stage, including whatever is issuing alongside it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        p_valid[i]  <= 1'b0;
        p_type[i]   <= '0;
        p_target[i] <= '0;
        p_fall[i]   <= '0;
        p_pred[i]   <= 1'b0;
        p_idx[i]    <= '0;
      end
    end else if (!stall) begin
      p_valid[0]  <= issue_valid && !redirect;
      p_type[0]   <= issue_type;
      p_target[0] <= issue_target;
      p_fall[0]   <= issue_fall;
      p_pred[0]   <= predict_taken;
      p_idx[0]    <= issue_idx;
      for (int i = 1; i < DEPTH; i++) begin
        p_valid[i]  <= p_valid[i-1] && !redirect;
        p_type[i]   <= p_type[i-1];
        p_target[i] <= p_target[i-1];
        p_fall[i]   <= p_fall[i-1];
        p_pred[i]   <= p_pred[i-1];
        p_idx[i]    <= p_idx[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (!stall && p_valid[R] && r_cond) begin
      if (r_taken && bht[p_idx[R]] != 2'b11)
        bht[p_idx[R]] <= bht[p_idx[R]] + 2'b01;
      else if (!r_taken && bht[p_idx[R]] != 2'b00)
        bht[p_idx[R]] <= bht[p_idx[R]] - 2'b01;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      mispredict_count <= '0;
    else if (r_mispredict && mispredict_count != 16'hFFFF)
      mispredict_count <= mispredict_count + 16'd1;
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve (default parameters: DEPTH=2, 16-entry BHT, PC_OFFSET=8).
module tb_branch_resolve;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [2:0]  issue_type;
  logic [31:0] issue_pc;
  logic [31:0] issue_imm;
  logic [31:0] issue_rs1;
  logic        stall;
  logic        flag_eq;
  logic        flag_lt;
  logic        predict_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] BEQ  = 3'b000, BNE  = 3'b001, JAL  = 3'b010, JALR = 3'b011;
  localparam logic [2:0] BLT  = 3'b100, BGEU = 3'b111, BLTU = 3'b110;

  branch_resolve dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_type(issue_type),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_rs1(issue_rs1), .stall(stall),
    .flag_eq(flag_eq), .flag_lt(flag_lt), .predict_taken(predict_taken),
    .redirect(redirect), .redirect_pc(redirect_pc), .mispredict_count(mispredict_count)
  );

  always #5 clock = ~clock;

  task tick;
    @(posedge clock);
    #1;
  endtask

  task idle_inputs;
    issue_valid = 0; issue_type = 0; issue_pc = 0; issue_imm = 0; issue_rs1 = 0;
    stall = 0; flag_eq = 0; flag_lt = 0;
  endtask

  task do_reset;
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task set_issue(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] imm,
                 input logic [31:0] rs1);
    issue_valid = 1; issue_type = t; issue_pc = pc; issue_imm = imm; issue_rs1 = rs1;
  endtask

  // Issue one instruction alone, then present flags in its resolve cycle.
  task do_branch(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] imm,
                 input logic [31:0] rs1, input logic eq, input logic lt,
                 output logic pred, output logic redir, output logic [31:0] rpc);
    set_issue(t, pc, imm, rs1);
    #1 pred = predict_taken;
    tick();
    issue_valid = 0;
    tick();
    flag_eq = eq; flag_lt = lt;
    #1;
    redir = redirect;
    rpc   = redirect_pc;
    tick();
    flag_eq = 0; flag_lt = 0;
  endtask

  task test_reset;
    idle_inputs();
    reset = 1;
    set_issue(BEQ, 32'h108, 32'h20, 0);
    flag_eq = 1;
    tick();
    tick();
    checks++;
    if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %0h expected 0", redirect); end
    checks++;
    if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %0h expected 0", redirect_pc); end
    checks++;
    if (predict_taken !== 1'b0) begin errors++; $display("FAIL reset_predict: got %0h expected 0", predict_taken); end
    checks++;
    if (mispredict_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %0h expected 0", mispredict_count); end
    do_reset();
  endtask

  task test_beq_taken;
    logic p, r; logic [31:0] rpc;
    do_reset();
    do_branch(BEQ, 32'h108, 32'h20, 0, 1, 0, p, r, rpc);
    checks++;
    if (p !== 1'b0) begin errors++; $display("FAIL beq_pred: got %0h expected 0", p); end
    checks++;
    if (r !== 1'b1) begin errors++; $display("FAIL beq_redirect: got %0h expected 1", r); end
    checks++;
    if (rpc !== 32'h120) begin errors++; $display("FAIL beq_target: got %0h expected 120", rpc); end
    checks++;
    if (mispredict_count !== 16'd1) begin errors++; $display("FAIL beq_count: got %0d expected 1", mispredict_count); end
  endtask

  task test_bht_training;
    logic p, r; logic [31:0] rpc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_branch(BEQ, 32'h108, 32'h20, 0, 1, 0, p, r, rpc);
      checks++;
      if (p !== (i != 0)) begin errors++; $display("FAIL train_pred%0d: got %0h expected %0h", i, p, (i != 0)); end
      checks++;
      if (r !== (i == 0)) begin errors++; $display("FAIL train_redirect%0d: got %0h expected %0h", i, r, (i == 0)); end
    end
    do_branch(BEQ, 32'h108, 32'h20, 0, 0, 0, p, r, rpc);
    checks++;
    if (p !== 1'b1) begin errors++; $display("FAIL train_pred3: got %0h expected 1", p); end
    checks++;
    if (r !== 1'b1 || rpc !== 32'h104) begin errors++; $display("FAIL train_fallthrough: got %0h/%0h expected 1/104", r, rpc); end
    checks++;
    if (mispredict_count !== 16'd2) begin errors++; $display("FAIL train_count: got %0d expected 2", mispredict_count); end
  endtask

  task test_jumps;
    logic p, r; logic [31:0] rpc;
    do_reset();
    do_branch(JALR, 32'h108, 32'h4, 32'h1003, 0, 0, p, r, rpc);
    checks++;
    if (p !== 1'b0) begin errors++; $display("FAIL jalr_pred: got %0h expected 0", p); end
    checks++;
    if (r !== 1'b1 || rpc !== 32'h1006) begin errors++; $display("FAIL jalr_target: got %0h/%0h expected 1/1006", r, rpc); end
    checks++;
    if (mispredict_count !== 16'd0) begin errors++; $display("FAIL jalr_count: got %0d expected 0", mispredict_count); end
    do_branch(BEQ, 32'h108, 32'h20, 0, 0, 0, p, r, rpc);
    checks++;
    if (p !== 1'b0 || r !== 1'b0 || rpc !== 32'h0) begin errors++; $display("FAIL jalr_bht_untouched: got %0h/%0h/%0h expected 0/0/0", p, r, rpc); end
    do_branch(JAL, 32'h208, 32'hFFFF_FFF0, 0, 0, 0, p, r, rpc);
    checks++;
    if (r !== 1'b1 || rpc !== 32'h1F0) begin errors++; $display("FAIL jal_target: got %0h/%0h expected 1/1f0", r, rpc); end
  endtask

  task test_mixed_conditions;
    logic p, r; logic [31:0] rpc;
    do_reset();
    do_branch(BNE, 32'h108, 32'h20, 0, 1, 0, p, r, rpc);
    checks++;
    if (r !== 1'b0 || rpc !== 32'h0) begin errors++; $display("FAIL bne_not_taken: got %0h/%0h expected 0/0", r, rpc); end
    do_branch(BGEU, 32'h308, 32'h100, 0, 0, 0, p, r, rpc);
    checks++;
    if (r !== 1'b1 || rpc !== 32'h400) begin errors++; $display("FAIL bgeu_taken: got %0h/%0h expected 1/400", r, rpc); end
    do_branch(BLTU, 32'h30C, 32'h100, 0, 0, 0, p, r, rpc);
    checks++;
    if (r !== 1'b0) begin errors++; $display("FAIL bltu_not_taken: got %0h expected 0", r); end
    checks++;
    if (mispredict_count !== 16'd1) begin errors++; $display("FAIL mixed_count: got %0d expected 1", mispredict_count); end
  endtask

  task test_back_to_back;
    logic p, r; logic [31:0] rpc;
    do_reset();
    set_issue(BEQ, 32'h108, 32'h20, 0);
    tick();
    set_issue(BNE, 32'h10C, 32'h40, 0);
    tick();
    flag_eq = 1;
    #1;
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h120) begin errors++; $display("FAIL b2b_first: got %0h/%0h expected 1/120", redirect, redirect_pc); end
    tick();
    issue_valid = 0;
    flag_eq = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (redirect !== 1'b0) begin errors++; $display("FAIL b2b_squash%0d: got %0h expected 0", i, redirect); end
      tick();
    end
    checks++;
    if (mispredict_count !== 16'd1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", mispredict_count); end
    do_branch(BNE, 32'h10C, 32'h40, 0, 0, 0, p, r, rpc);
    checks++;
    if (p !== 1'b0) begin errors++; $display("FAIL b2b_bht_untouched: got %0h expected 0", p); end
    checks++;
    if (r !== 1'b1 || rpc !== 32'h144) begin errors++; $display("FAIL b2b_bne_target: got %0h/%0h expected 1/144", r, rpc); end
  endtask

  task test_stall;
    do_reset();
    set_issue(BLT, 32'h108, 32'h40, 0);
    tick();
    issue_valid = 0;
    tick();
    stall = 1;
    flag_lt = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL stall_hold%0d: got %0h/%0h expected 0/0", i, redirect, redirect_pc); end
      tick();
    end
    checks++;
    if (mispredict_count !== 16'd0) begin errors++; $display("FAIL stall_count_held: got %0d expected 0", mispredict_count); end
    stall = 0;
    #1;
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h140) begin errors++; $display("FAIL stall_release: got %0h/%0h expected 1/140", redirect, redirect_pc); end
    tick();
    flag_lt = 0;
    #1;
    checks++;
    if (mispredict_count !== 16'd1 || redirect !== 1'b0) begin errors++; $display("FAIL stall_after: got %0d/%0h expected 1/0", mispredict_count, redirect); end
  endtask

  task test_reset_mid;
    logic p, r; logic [31:0] rpc;
    do_reset();
    set_issue(JAL, 32'h108, 32'h10, 0);
    tick();
    issue_valid = 0;
    reset = 1;
    #1;
    checks++;
    if (redirect !== 1'b0) begin errors++; $display("FAIL rmid_during: got %0h expected 0", redirect); end
    tick();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (redirect !== 1'b0) begin errors++; $display("FAIL rmid_after%0d: got %0h expected 0", i, redirect); end
      tick();
    end
    checks++;
    if (mispredict_count !== 16'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", mispredict_count); end
    do_branch(BEQ, 32'h108, 32'h20, 0, 0, 0, p, r, rpc);
    checks++;
    if (p !== 1'b0 || r !== 1'b0) begin errors++; $display("FAIL rmid_bht: got %0h/%0h expected 0/0", p, r); end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bht_training();
    test_jumps();
    test_mixed_conditions();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter XLEN, default 32, address/data width.
REQ-002 Parameter DEPTH, default 2, pipeline stages from issue to resolve, legal range 1..8.
REQ-003 Parameter BHT_ENTRIES, default 16, prediction table entries, power of two, minimum 2.
REQ-004 Parameter PC_OFFSET, default 8, constant subtracted from issue_pc to form the instruction's own address.
REQ-005 Reset is reset, synchronous, active-high; the clock is clock.
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 issue_valid  in  1  control-transfer instruction presented this cycle.
REQ-009 issue_type  in  3  000 BEQ, 001 BNE, 010 JAL, 011 JALR, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-010 issue_pc, issue_imm, issue_rs1  in  XLEN each  fetch PC, sign-extended immediate, JALR base register.
REQ-011 stall  in  1  freezes the whole block.
REQ-012 flag_eq, flag_lt  in  1 each  ALU result for the instruction in the resolve stage; flag_lt is signed or unsigned per type.
REQ-013 predict_taken  out  1  combinational BHT prediction for the issuing branch.
REQ-014 redirect  out  1  fetch must load redirect_pc; same as the pipeline flush.
REQ-015 redirect_pc  out  XLEN  corrected fetch address.
REQ-016 mispredict_count  out  16  saturating count of conditional mispredictions.

Function
REQ-017 ia = issue_pc - PC_OFFSET. Branch/JAL target = ia + issue_imm. JALR target = (issue_rs1 + issue_imm) with bit 0 cleared. Fall-through = ia + 4. All sums are modulo 2^XLEN.
REQ-018 The block computes these values at issue. It carries them, with type, valid, prediction and BHT index, through a DEPTH-stage shift pipeline.
REQ-019 BHT index = ia[log2(BHT_ENTRIES)+1:2]. Each entry is a 2-bit saturating counter. predict_taken = counter[1] when issue_valid is high and the type is conditional; otherwise predict_taken = 0.
REQ-020 Resolve stage, taken condition: BEQ flag_eq=1; BNE flag_eq=0; BLT and BLTU flag_lt=1; BGE and BGEU flag_lt=0; JAL and JALR always taken.
REQ-021 Conditional branch: redirect=1 when actual != predicted. redirect_pc = target if actual is taken, else fall-through.
REQ-022 JAL and JALR: redirect=1 always, redirect_pc = target. No BHT access, no count change.
REQ-023 redirect and redirect_pc are combinational from the resolve stage. When redirect=0, redirect_pc=0.
REQ-024 Resolve-stage update (conditional branch only): the counter increments if taken, saturating at 3, and decrements if not taken, saturating at 0. On each mispredict, mispredict_count increments, saturating at 16'hFFFF.
REQ-025 On redirect, the next edge clears valid in all pipeline stages. This includes any entry issued in the redirect cycle, which is wrong-path.
REQ-026 stall=1: pipeline, BHT and counter hold. redirect is forced to 0, and the held resolve entry resolves once stall drops.
REQ-027 BHT update and lookup of the same index in the same cycle: the lookup returns the pre-update value.
REQ-028 Latency: an instruction issued at edge N (no stall) resolves in the cycle after edge N+DEPTH-1. With DEPTH=2, redirect is visible 2 cycles after issue.

Reset
REQ-029 Reset clears all pipeline valid bits, type, PC and prediction fields to 0. All BHT counters go to 2'b01 (weakly not-taken), and mispredict_count goes to 0.
REQ-030 During and immediately after reset, redirect=0, redirect_pc=0, predict_taken=0. Reset mid-operation discards in-flight entries without redirect.
REQ-031 Reset has priority over stall and issue_valid.

Verification
REQ-032 Fresh reset, BEQ, pc=0x108, imm=0x20, flag_eq=1 at resolve -> predict_taken=0; redirect=1 with redirect_pc=0x120, 2 cycles after issue; mispredict_count=1.
REQ-033 Same BEQ issued three times taken -> predictions 0, 1, 1; counter reaches 3; only the first redirects; a fourth not-taken issue redirects to 0x104.
REQ-034 JALR, rs1=0x1003, imm=0x4 -> redirect_pc=0x1006; redirect=1; BHT and count unchanged.
REQ-035 Redirecting branch followed by a BNE issued in the next two cycles -> the younger BNE is squashed, with no redirect and no BHT update.
REQ-036 stall held 3 cycles while a BLT sits in the resolve stage -> redirect=0 throughout; resolves correctly on the first unstalled cycle.
REQ-037 reset asserted one cycle after a JAL issue -> no redirect ever; mispredict_count=0; BHT at 2'b01.
